// File: rtl/alu_seq.sv
// alu_seq: multi-pass controller that runs wide add/sub/and/or commands
// through a shared 8-bit ALU, one byte per pass, LSB first, chaining carry.
module alu_seq #(
    parameter int unsigned NBYTES   = 2,
    parameter logic [2:0]  OPT_IDLE = 3'd0,
    parameter logic [2:0]  OPT_ADD  = 3'd1,
    parameter logic [2:0]  OPT_SUB  = 3'd2,
    parameter logic [2:0]  OPT_AND  = 3'd3,
    parameter logic [2:0]  OPT_OR   = 3'd4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [8*NBYTES-1:0]   cmd_a,
    input  logic [8*NBYTES-1:0]   cmd_b,
    output logic [2:0]            alu_opt,
    output logic [7:0]            alu_numa,
    output logic [7:0]            alu_numb,
    output logic                  alu_ci,
    input  logic [7:0]            alu_s,
    input  logic                  alu_zero,
    input  logic                  alu_co,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [8*NBYTES-1:0]   res_s,
    output logic                  res_co,
    output logic                  res_zero
);

    localparam int unsigned W        = 8 * NBYTES;
    localparam logic [2:0]  LAST_IDX = 3'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic           carry_q, carry_d;
    logic           zacc_q, zacc_d;
    logic [W-1:0]   res_s_q, res_s_d;
    logic           res_co_q, res_co_d;
    logic           res_zero_q, res_zero_d;
    logic           res_valid_q, res_valid_d;
    logic           cmd_ready_q, cmd_ready_d;

    logic [7:0]     byte_a;
    logic [7:0]     byte_b;
    logic           op_arith;

    assign op_arith = ~op_q[1];

    // Drive the ALU from registered state; idle code whenever no pass is active.
    always_comb begin
        byte_a = '0;
        byte_b = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (idx_q == 3'(i)) begin
                byte_a = a_q[i*8 +: 8];
                byte_b = b_q[i*8 +: 8];
            end
        end
        alu_opt  = OPT_IDLE;
        alu_numa = '0;
        alu_numb = '0;
        alu_ci   = 1'b0;
        if (state_q == RUN) begin
            case (op_q)
                2'd0:    alu_opt = OPT_ADD;
                2'd1:    alu_opt = OPT_SUB;
                2'd2:    alu_opt = OPT_AND;
                default: alu_opt = OPT_OR;
            endcase
            alu_numa = byte_a;
            alu_numb = byte_b;
            alu_ci   = op_arith & carry_q;
        end
    end

    // Next-state and registered-output computation for the pass sequencer.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        zacc_d      = zacc_q;
        res_s_d     = res_s_q;
        res_co_d    = res_co_q;
        res_zero_d  = res_zero_q;
        res_valid_d = res_valid_q;
        cmd_ready_d = cmd_ready_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d        = cmd_op;
                    a_d         = cmd_a;
                    b_d         = cmd_b;
                    idx_d       = '0;
                    carry_d     = 1'b0;
                    zacc_d      = 1'b1;
                    cmd_ready_d = 1'b0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < NBYTES; i++) begin
                    if (idx_q == 3'(i)) begin
                        res_s_d[i*8 +: 8] = alu_s;
                    end
                end
                carry_d = alu_co;
                zacc_d  = zacc_q & alu_zero;
                if (idx_q == LAST_IDX) begin
                    res_co_d    = op_arith & alu_co;
                    res_zero_d  = zacc_q & alu_zero;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                res_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    // State register; async reset drops any in-flight command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            zacc_q      <= 1'b0;
            res_s_q     <= '0;
            res_co_q    <= 1'b0;
            res_zero_q  <= 1'b0;
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            zacc_q      <= zacc_d;
            res_s_q     <= res_s_d;
            res_co_q    <= res_co_d;
            res_zero_q  <= res_zero_d;
            res_valid_q <= res_valid_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign res_valid = res_valid_q;
    assign res_s     = res_s_q;
    assign res_co    = res_co_q;
    assign res_zero  = res_zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven and scoreboarded checks of alu_seq with a
// behavioural 8-bit ALU attached to its ALU ports.
module tb_alu_seq;

    localparam int unsigned NB = 2;
    localparam int unsigned W  = 8 * NB;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_s;
        logic         exp_co;
        logic         exp_zero;
    } vec_t;

    logic           clk;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [1:0]     cmd_op;
    logic [W-1:0]   cmd_a;
    logic [W-1:0]   cmd_b;
    logic [2:0]     alu_opt;
    logic [7:0]     alu_numa;
    logic [7:0]     alu_numb;
    logic           alu_ci;
    logic [7:0]     alu_s;
    logic           alu_zero;
    logic           alu_co;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_s;
    logic           res_co;
    logic           res_zero;

    int checks = 0;
    int errors = 0;
    vec_t sb[$];

    alu_seq #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_opt   (alu_opt),
        .alu_numa  (alu_numa),
        .alu_numb  (alu_numb),
        .alu_ci    (alu_ci),
        .alu_s     (alu_s),
        .alu_zero  (alu_zero),
        .alu_co    (alu_co),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_s     (res_s),
        .res_co    (res_co),
        .res_zero  (res_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8-bit ALU.
    always_comb begin
        logic [8:0] t;
        t = '0;
        case (alu_opt)
            3'd1: t = {1'b0, alu_numa} + {1'b0, alu_numb} + {8'd0, alu_ci};
            3'd2: t = {1'b0, alu_numa} - {1'b0, alu_numb} - {8'd0, alu_ci};
            3'd3: t = {1'b0, alu_numa & alu_numb};
            3'd4: t = {1'b0, alu_numa | alu_numb};
            default: t = '0;
        endcase
        alu_s    = t[7:0];
        alu_co   = t[8];
        alu_zero = (t[7:0] == 8'd0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t v;
        v.op = op;
        v.a  = a;
        v.b  = b;
        case (op)
            2'd0: begin v.exp_s = a + b; v.exp_co = ({1'b0, a} + {1'b0, b}) > {1'b0, {W{1'b1}}}; end
            2'd1: begin v.exp_s = a - b; v.exp_co = (a < b); end
            2'd2: begin v.exp_s = a & b; v.exp_co = 1'b0; end
            default: begin v.exp_s = a | b; v.exp_co = 1'b0; end
        endcase
        v.exp_zero = (v.exp_s == '0);
        return v;
    endfunction

    // Carry/borrow expected into pass k, from the low k bytes of the operands.
    function automatic logic pass_ci(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int k);
        longint unsigned m, la, lb;
        if (k == 0 || op[1]) return 1'b0;
        m  = (64'd1 << (8 * k)) - 64'd1;
        la = 64'(a) & m;
        lb = 64'(b) & m;
        if (op == 2'd0) return (la + lb) > m;
        return la < lb;
    endfunction

    // Issue one command, check each pass and the result; optionally release it.
    task automatic run_cmd(input vec_t v, input bit release_it);
        int   n;
        bit   got;
        vec_t e;
        @(negedge clk);
        check("cmd_ready_before", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_a     = v.a;
        cmd_b     = v.b;
        sb.push_back(v);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (res_valid) begin
                got = 1'b1;
            end else if (n <= int'(NB)) begin
                check("pass_opt",  64'(alu_opt),  64'(v.op) + 64'd1);
                check("pass_numa", 64'(alu_numa), 64'((v.a >> (8 * (n - 1))) & 16'h00FF));
                check("pass_numb", 64'(alu_numb), 64'((v.b >> (8 * (n - 1))) & 16'h00FF));
                check("pass_ci",   64'(alu_ci),   64'(pass_ci(v.op, v.a, v.b, n - 1)));
                check("run_cmd_ready", 64'(cmd_ready), 64'd0);
            end
        end
        e = sb.pop_front();
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL res_valid_timeout actual=0 expected=1");
        end else begin
            check("latency",  64'(n), 64'(NB + 1));
            check("res_s",    64'(res_s),    64'(e.exp_s));
            check("res_co",   64'(res_co),   64'(e.exp_co));
            check("res_zero", 64'(res_zero), 64'(e.exp_zero));
            if (release_it) begin
                res_ready = 1'b1;
                @(posedge clk);
                #1 res_ready = 1'b0;
                check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
                check("idle_res_valid", 64'(res_valid), 64'd0);
                check("idle_alu_opt",   64'(alu_opt),   64'd0);
            end
        end
    endtask

    vec_t tbl[8];
    vec_t bp;

    initial begin
        tbl[0] = '{2'd0, 16'h12FF, 16'h0001, 16'h1300, 1'b0, 1'b0};
        tbl[1] = '{2'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
        tbl[2] = '{2'd1, 16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0};
        tbl[3] = '{2'd1, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0};
        tbl[4] = '{2'd2, 16'h5555, 16'hAAAA, 16'h0000, 1'b0, 1'b1};
        tbl[5] = '{2'd3, 16'h5555, 16'hAAAA, 16'hFFFF, 1'b0, 1'b0};
        tbl[6] = '{2'd1, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1};
        tbl[7] = '{2'd0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_s",     64'(res_s),     64'd0);
        check("rst_res_co",    64'(res_co),    64'd0);
        check("rst_res_zero",  64'(res_zero),  64'd0);
        check("rst_alu_opt",   64'(alu_opt),   64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_cmd(tbl[i], 1'b1);

        for (int i = 0; i < 10; i++) begin
            run_cmd(model(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom)), 1'b1);
        end

        // Backpressure: result held, new command ignored.
        bp = model(2'd0, 16'h0102, 16'h0304);
        run_cmd(bp, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            cmd_valid = (c == 1);
            cmd_op    = 2'd1;
            cmd_a     = 16'hAAAA;
            cmd_b     = 16'h1111;
            check("bp_res_valid", 64'(res_valid), 64'd1);
            check("bp_res_s",     64'(res_s),     64'h0406);
            check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        check("bp_rel_cmd_ready", 64'(cmd_ready), 64'd1);
        check("bp_rel_res_valid", 64'(res_valid), 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("bp_no_capture_valid", 64'(res_valid), 64'd0);
            check("bp_no_capture_opt",   64'(alu_opt),   64'd0);
        end

        // Reset during the first RUN pass drops the command.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'd0;
        cmd_a     = 16'h1111;
        cmd_b     = 16'h2222;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check("pre_rst_alu_opt", 64'(alu_opt), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_alu_opt",   64'(alu_opt),   64'd0);
        check("mid_rst_res_valid", 64'(res_valid), 64'd0);
        check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("dropped_res_valid", 64'(res_valid), 64'd0);
        end
        run_cmd('{2'd0, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0}, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Multi-pass controller that owns the shared 8-bit ALU and runs wide (8*NBYTES-bit) add/sub/and/or commands as one ALU pass per byte, least significant byte first, chaining carry/borrow between passes. A requester hands it a command over a valid/ready handshake and takes the assembled result back over a second valid/ready handshake. It sits between the calculator control logic and the ALU instance, and is the only driver of the ALU inputs.

Parameters:
NBYTES, 2, number of 8-bit passes per command; operand/result width W = 8*NBYTES; legal range 1..8
OPT_IDLE, 3'd0, ALU opt code driven when no pass is active
OPT_ADD, 3'd1, ALU add: s = numa + numb + ci, co = carry out
OPT_SUB, 3'd2, ALU subtract: s = numa - numb - ci, co = borrow out
OPT_AND, 3'd3, ALU bitwise AND
OPT_OR, 3'd4, ALU bitwise OR

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept a command
cmd_op  in  2  0 add, 1 sub, 2 and, 3 or
cmd_a  in  W  operand A
cmd_b  in  W  operand B
alu_opt  out  3  to ALU opt
alu_numa  out  8  to ALU numa
alu_numb  out  8  to ALU numb
alu_ci  out  1  to ALU ci
alu_s  in  8  ALU result
alu_zero  in  1  ALU zero flag
alu_co  in  1  ALU carry/borrow out
res_valid  out  1  result present
res_ready  in  1  requester takes result
res_s  out  W  result
res_co  out  1  final carry (add) / borrow (sub); 0 for and/or
res_zero  out  1  1 iff res_s == 0

Behaviour:
- States: IDLE, RUN, DONE. Byte index idx counts 0..NBYTES-1.
- Reset (async, any state): state IDLE, idx 0, captured operands/op cleared, res_s 0, res_co 0, res_zero 0, res_valid 0, cmd_ready 1. An in-flight command is dropped and produces no result.
- IDLE: cmd_ready = 1. When cmd_valid is high at a rising edge, capture cmd_op/cmd_a/cmd_b, set idx = 0, clear the carry register, set the zero accumulator to 1, and go to RUN.
- RUN: cmd_ready = 0. ALU outputs are combinational from registered state: alu_opt is the opcode mapped from the captured op, alu_numa/alu_numb are byte idx of the captured A/B, and alu_ci is the carry register for add/sub (0 in the first pass) and 0 for and/or.
- RUN, at each edge: write alu_s into byte idx of res_s, update carry register = alu_co, and zero accumulator &= alu_zero. If idx == NBYTES-1, go to DONE with res_co = alu_co for add/sub and 0 for and/or, and res_zero = final accumulator value. Otherwise idx++.
- Outside RUN: alu_opt = OPT_IDLE, alu_numa = 0, alu_numb = 0, alu_ci = 0.
- DONE: res_valid = 1, and res_s/res_co/res_zero are held stable. Return to IDLE on the edge where res_ready = 1. cmd_valid is ignored in DONE, with no capture.
- Latency: the command is accepted on edge E, and res_valid rises after edge E+NBYTES (2 cycles with the default). Minimum spacing between accepted commands is NBYTES+2 cycles.
- res_s is written only in RUN. Its bytes may update during RUN but are valid only while res_valid = 1.
- Arithmetic is modulo 2^W. Sub result = A - B mod 2^W, and res_co = 1 iff A < B (unsigned).
- cmd_op values 2/3 never propagate carry. All 2-bit op values are legal.

Test Plan:
1. add, A=0x12FF, B=0x0001 -> pass0 alu_numa=0xFF alu_numb=0x01 alu_ci=0; pass1 alu_numa=0x12 alu_ci=1; result res_s=0x1300, res_co=0, res_zero=0, res_valid 2 cycles after accept.
2. add, A=0xFFFF, B=0x0001 -> res_s=0x0000, res_co=1, res_zero=1.
3. sub, A=0x0100, B=0x0001 -> pass1 alu_ci=1; result res_s=0x00FF, res_co=0, res_zero=0. Also sub A=0x0003, B=0x0005 -> res_s=0xFFFE, res_co=1.
4. and, A=0x5555, B=0xAAAA -> alu_opt=3 and alu_ci=0 on both passes; result res_s=0x0000, res_zero=1, res_co=0. Also or on the same operands -> res_s=0xFFFF, res_zero=0.
5. Backpressure: hold res_ready=0 for 5 cycles after res_valid rises and pulse cmd_valid with a new op -> res_valid and res_s stay stable, cmd_ready=0, and the new command is not captured. Then res_ready=1 -> IDLE next cycle with cmd_ready=1.
6. Assert rst during the first RUN pass -> outputs go to reset values immediately (alu_opt=0, res_valid=0, cmd_ready=1). After release, a fresh add 0x0002+0x0003 gives res_s=0x0005.
